// File: rtl/uart_defs.sv
// -----------------------------------------------------------------------------
// uart_defs
//   Shared definitions for the UART receiver slice. This package holds the
//   receive and handshake FSM state encodings, the default bit period, and the
//   frame constants.
//
//   Build option: UART_RX_PARITY_EN adds the R_PARITY receive state.
// -----------------------------------------------------------------------------
package uart_defs;

  // 50 MHz / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  // 8N1 frame layout
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    R_IDLE   = 3'd0,
    R_START  = 3'd1,
    R_DATA   = 3'd2,
    R_STOP   = 3'd3,
    R_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
    ,
    R_PARITY = 3'd5
`endif
  } rx_state_e;

  typedef enum logic [1:0] {
    H_EMPTY = 2'd0,
    H_FULL  = 2'd1,
    H_REQ   = 2'd2,
    H_ACK   = 2'd3
  } hsk_state_e;

endpackage

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
//   Two-flop synchroniser for asynchronous inputs. The reset value is
//   parameterised so that idle-high lines come out of reset already idle.
//
//   Ports:
//     clk    - destination clock
//     rst_n  - asynchronous active-low reset (both stages load RESET_VAL)
//     d      - asynchronous input, WIDTH bits
//     q      - synchronised output, WIDTH bits
// -----------------------------------------------------------------------------
module sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: non-blocking assignments make both stages sample their pre-edge
  // inputs; blocking would collapse the chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_hsk.sv
// -----------------------------------------------------------------------------
// uart_rx_hsk
//   8N1 UART receiver feeding comm_handler over a 4-phase req/ack byte
//   handshake. The receiver runs independently of the consumer. A single
//   holding register carries the byte across the handshake. A byte that
//   completes while the holder is busy is dropped and flagged as overrun.
//
//   Build option: UART_RX_PARITY_EN inserts a parity bit after the data bits.
//   It adds the parameter PARITY_ODD and the output out_parity_err.
//
//   Ports:
//     in_clk              - system clock
//     in_rst_n            - asynchronous active-low reset
//     in_uart_rx          - asynchronous serial line, idle high
//     in_rx_enable        - consumer ready to start a handshake
//     out_data_rx         - held byte, stable from load until the handshake ends
//     out_data_rx_hsk_req - byte-valid request (registered)
//     in_data_rx_hsk_ack  - acknowledge from consumer
//     out_frame_err       - 1-cycle pulse: stop bit sampled low
//     out_overrun         - 1-cycle pulse: byte dropped, holder was busy
//     out_parity_err      - (parity build only) 1-cycle pulse at stop sample
// -----------------------------------------------------------------------------
module uart_rx_hsk
  import uart_defs::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD   = 1'b0
`endif
) (
  input  logic       in_clk,
  input  logic       in_rst_n,
  input  logic       in_uart_rx,
  input  logic       in_rx_enable,
  output logic [7:0] out_data_rx,
  output logic       out_data_rx_hsk_req,
  input  logic       in_data_rx_hsk_ack,
  output logic       out_frame_err,
  output logic       out_overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       out_parity_err
`endif
);

  // Counter runs 0 .. CLKS_PER_BIT-1, so $clog2 bits always suffice.
  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  logic rx_s;

  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             frame_err_q, frame_err_d;
  logic             byte_done;

  hsk_state_e       hsk_q, hsk_d;
  logic [7:0]       data_q, data_d;
  logic             req_q, req_d;
  logic             overrun_q, overrun_d;

`ifdef UART_RX_PARITY_EN
  logic             par_bad_q, par_bad_d;
  logic             parity_err_q, parity_err_d;
`endif

  sync2 #(
    .WIDTH    (1),
    .RESET_VAL(1'b1)
  ) u_sync_rx (
    .clk  (in_clk),
    .rst_n(in_rst_n),
    .d    (in_uart_rx),
    .q    (rx_s)
  );

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default before the case statement,
  // so no path can leave a value unassigned and infer a latch.
  always_comb begin
    rx_state_d  = rx_state_q;
    cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    byte_done   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    unique case (rx_state_q)
      R_IDLE: begin
        cnt_d = '0;
        if (!rx_s) rx_state_d = R_START;
      end

      // Mid start bit: a line already back high was only a glitch.
      R_START: begin
        if (cnt_q == CNT_MID) begin
          if (rx_s) begin
            rx_state_d = R_IDLE;
          end else begin
            cnt_d      = '0;
            bit_idx_d  = '0;
            rx_state_d = R_DATA;
`ifdef UART_RX_PARITY_EN
            par_bad_d  = 1'b0;
`endif
          end
        end
      end

      // The counter was re-phased at mid start bit, so each wrap lands mid-bit.
      R_DATA: begin
        if (cnt_q == CNT_LAST) begin
          shreg_d   = {rx_s, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            rx_state_d = R_PARITY;
`else
            rx_state_d = R_STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      R_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          par_bad_d  = ((^shreg_q) ^ rx_s) != PARITY_ODD;
          rx_state_d = R_STOP;
        end
      end
`endif

      R_STOP: begin
        if (cnt_q == CNT_LAST) begin
`ifdef UART_RX_PARITY_EN
          parity_err_d = par_bad_q;
`endif
          if (rx_s) begin
`ifdef UART_RX_PARITY_EN
            byte_done = !par_bad_q;
`else
            byte_done = 1'b1;
`endif
            rx_state_d = R_IDLE;
          end else begin
            frame_err_d = 1'b1;
            rx_state_d  = R_BREAK;
          end
        end
      end

      // A held-low line must see a rising edge before any new frame can start.
      R_BREAK: begin
        cnt_d = '0;
        if (rx_s) rx_state_d = R_IDLE;
      end

      default: begin
        cnt_d      = '0;
        rx_state_d = R_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM and holding register
  // ---------------------------------------------------------------------------
  always_comb begin
    hsk_d     = hsk_q;
    data_d    = data_q;
    overrun_d = 1'b0;

    unique case (hsk_q)
      H_EMPTY: begin
        if (byte_done) begin
          data_d = shreg_q;
          hsk_d  = H_FULL;
        end
      end
      H_FULL:  if (in_rx_enable)        hsk_d = H_REQ;
      H_REQ:   if (in_data_rx_hsk_ack)  hsk_d = H_ACK;
      H_ACK:   if (!in_data_rx_hsk_ack) hsk_d = H_EMPTY;
      default: hsk_d = H_EMPTY;
    endcase

    // The holder only reloads from H_EMPTY. A byte finishing on the
    // H_ACK->H_EMPTY cycle is therefore dropped as well.
    if (byte_done && (hsk_q != H_EMPTY)) overrun_d = 1'b1;

    req_d = (hsk_d == H_REQ);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      rx_state_q  <= R_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      hsk_q       <= H_EMPTY;
      data_q      <= '0;
      req_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      hsk_q       <= hsk_d;
      data_q      <= data_d;
      req_q       <= req_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign out_parity_err = parity_err_q;
`endif

  assign out_data_rx         = data_q;
  assign out_data_rx_hsk_req = req_q;
  assign out_frame_err       = frame_err_q;
  assign out_overrun         = overrun_q;

endmodule

// File: tb/tb_uart_rx_hsk.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_hsk
//   Scoreboard bench for uart_rx_hsk with CLKS_PER_BIT = 8.
//
//   The stimulus drives serial frames. For each frame that should be
//   delivered, it pushes the byte into a queue. For each expected error
//   condition, it bumps an expected pulse count.
//
//   A monitor pops the queue on every req rising edge and counts error
//   pulses. A responder process drives ack.
// -----------------------------------------------------------------------------
module tb_uart_rx_hsk;
  import uart_defs::*;

  localparam int CPB      = 8;
  localparam int MAX_WAIT = 200;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       uart_rx   = 1'b1;
  logic       rx_enable = 1'b1;
  logic       ack       = 1'b0;
  logic [7:0] data;
  logic       req;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  int         exp_frame_err = 0;
  int         exp_overrun   = 0;
  int         act_frame_err = 0;
  int         act_overrun   = 0;

  bit ack_en  = 1'b1;
  int ack_dly = 3;

  always #5 clk = ~clk;

  uart_rx_hsk #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .in_clk             (clk),
    .in_rst_n           (rst_n),
    .in_uart_rx         (uart_rx),
    .in_rx_enable       (rx_enable),
    .out_data_rx        (data),
    .out_data_rx_hsk_req(req),
    .in_data_rx_hsk_ack (ack),
    .out_frame_err      (frame_err),
    .out_overrun        (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .out_parity_err     (parity_err)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Line driver (all stimulus changes on the falling clock edge)
  // ---------------------------------------------------------------------------
  task automatic hold(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    hold(1'b0, CPB);
    for (int i = 0; i < DATA_BITS; i++) hold(b[i], CPB);
    for (int i = 0; i < STOP_BITS; i++) hold(stop_bit, CPB);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_sb_drained"}, exp_q.size(), 0);
    check({tag, "_frame_err_count"}, act_frame_err, exp_frame_err);
    check({tag, "_overrun_count"}, act_overrun, exp_overrun);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pops and compares on req rise, checks handshake and pulse rules
  // ---------------------------------------------------------------------------
  logic       req_prev = 1'b0;
  logic       ack_prev = 1'b0;
  logic       fe_prev  = 1'b0;
  logic       ov_prev  = 1'b0;
  logic [7:0] cur_exp  = '0;

  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      req_prev = 1'b0;
      ack_prev = 1'b0;
      fe_prev  = 1'b0;
      ov_prev  = 1'b0;
    end else begin
      if (req && !req_prev) begin
        check("sb_pending_at_req", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          cur_exp = exp_q.pop_front();
          check("data_at_req", data, cur_exp);
        end
      end else if (req) begin
        check("data_stable_during_req", data, cur_exp);
      end
      if (req_prev && ack_prev) check("req_drops_after_ack", req, 0);
      if (req_prev && !req)     check("ack_high_when_req_drops", ack, 1);
      if (frame_err) begin
        act_frame_err++;
        check("frame_err_one_cycle", fe_prev, 0);
      end
      if (overrun) begin
        act_overrun++;
        check("overrun_one_cycle", ov_prev, 0);
      end
      req_prev = req;
      ack_prev = ack;
      fe_prev  = frame_err;
      ov_prev  = overrun;
    end
  end

  // ---------------------------------------------------------------------------
  // Consumer: raise ack ack_dly cycles after req, drop it after req falls
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && ack_en && req && !ack) begin
        repeat (ack_dly - 1) @(negedge clk);
        ack = 1'b1;
        begin
          int w;
          w = 0;
          while (req && w < MAX_WAIT) begin
            @(negedge clk);
            w++;
          end
        end
        check("req_released_by_ack", req, 0);
        @(negedge clk);
        ack = 1'b0;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    repeat (3) @(negedge clk);
    check("reset_data", data, 0);
    check("reset_req", req, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    rst_n = 1'b1;
    hold(1'b1, 5);

    // Basic frame, ack 3 cycles after req
    ack_dly = 3;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    hold(1'b1, 30);
    check_counts("t1");

    // Consumer not ready: byte waits in the holder, req follows enable
    rx_enable = 1'b0;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    hold(1'b1, 50);
    check("t2_req_held_off", req, 0);
    check("t2_data_held", data, 8'h3C);
    rx_enable = 1'b1;
    @(posedge clk);
    #1;
    check("t2_req_one_cycle_after_enable", req, 1);
    @(negedge clk);
    hold(1'b1, 30);
    check_counts("t2");

    // Overrun: second byte arrives while the first is still unacknowledged
    ack_en = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    exp_overrun++;
    hold(1'b1, 20);
    check("t3_req_still_high", req, 1);
    check("t3_data_kept", data, 8'h11);
    ack_en = 1'b1;
    hold(1'b1, 30);
    check_counts("t3");

    // Framing error followed by a long break, then recovery
    send_frame(8'h55, 1'b0);
    exp_frame_err++;
    hold(1'b0, 40);
    hold(1'b1, 20);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    hold(1'b1, 30);
    check_counts("t4");

    // Short glitch on an idle line, then a real frame
    hold(1'b0, 2);
    hold(1'b1, 20);
    check("t5_no_req_after_glitch", req, 0);
    exp_q.push_back(8'h80);
    send_frame(8'h80, 1'b1);
    hold(1'b1, 30);
    check_counts("t5");

    // Reset in the middle of frame 0xFF: the partial byte must vanish
    hold(1'b0, CPB);
    hold(1'b1, 2 * CPB);
    rst_n = 1'b0;
    #1;
    check("t6_reset_data", data, 0);
    check("t6_reset_req", req, 0);
    check("t6_reset_frame_err", frame_err, 0);
    check("t6_reset_overrun", overrun, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hold(1'b1, 6 * CPB);
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1);
    hold(1'b1, 30);
    check_counts("t6");

    // Randomised mix of good frames, framing errors and glitches
    for (int n = 0; n < 30; n++) begin
      logic [7:0] b;
      int         kind;
      b       = 8'($urandom);
      kind    = $urandom_range(0, 9);
      ack_dly = $urandom_range(1, 5);
      if (kind == 0) begin
        send_frame(b, 1'b0);
        exp_frame_err++;
        hold(1'b0, $urandom_range(0, 30));
        hold(1'b1, 12);
      end else begin
        if (kind == 1) begin
          hold(1'b0, $urandom_range(1, 2));
          hold(1'b1, 15);
        end
        exp_q.push_back(b);
        send_frame(b, 1'b1);
        hold(1'b1, $urandom_range(20, 40));
      end
    end
    hold(1'b1, 50);
    check_counts("rand");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
